// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package mips_pkg;
  localparam int IMEM_ADDR_W      = 10;
  localparam int LOADER_HDR_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    CSUM
  } loader_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int ADDR_W = mips_pkg::IMEM_ADDR_W
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_rx_timeout.sv
// Idle-cycle counter: cleared by load, counts while enabled, flags expiry
// on the last idle cycle so the session aborts on that same edge.
module rx_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && !load && (cnt == LIMIT);
endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: frames a byte stream into big-endian words, writes them
// to instruction memory from address 0 and verifies an 8-bit payload sum.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W      = IMEM_ADDR_W,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [ADDR_W:0] words_loaded
);
  loader_state_t   state;
  logic [7:0]      n_hi;
  logic [ADDR_W:0] n_words;
  logic [7:0]      csum;
  logic [1:0]      byte_cnt;
  logic [23:0]     word_sr;
  logic [15:0]     n_hdr;
  logic            hdr_ok;
  logic            accept;
  logic            expired;

  assign accept        = bus.rx_valid && bus.rx_ready;
  assign n_hdr         = {n_hi, bus.rx_data};
  assign hdr_ok        = (n_hdr != 16'd0) && (int'(n_hdr) <= (1 << ADDR_W));
  assign bus.imem_addr = words_loaded[ADDR_W-1:0];

  // rx_ready is high exactly in the receiving states, so it doubles as the
  // timeout enable; the counter is held cleared while idle.
  rx_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (accept || (state == IDLE)),
    .enable (bus.rx_ready),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (accept && (state == DATA)) begin
      word_sr <= {word_sr[15:0], bus.rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_wdata <= '0;
      cpu_reset      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
      n_hi           <= '0;
      n_words        <= '0;
      csum           <= '0;
      byte_cnt       <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= HDR_HI;
            error        <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
            byte_cnt     <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b1;
            bus.rx_ready <= 1'b1;
          end
        end
        HDR_HI: begin
          if (accept) begin
            n_hi  <= bus.rx_data;
            state <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            if (hdr_ok) begin
              n_words <= (ADDR_W + 1)'(n_hdr);
              state   <= DATA;
            end else begin
              state        <= IDLE;
              error        <= 1'b1;
              busy         <= 1'b0;
              bus.rx_ready <= 1'b0;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum     <= csum + bus.rx_data;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              bus.imem_wdata <= {word_sr, bus.rx_data};
              bus.imem_we    <= 1'b1;
              bus.rx_ready   <= 1'b0;
              state          <= WRITE;
            end
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 1'b1;
          bus.rx_ready <= 1'b1;
          state        <= (words_loaded == n_words - 1'b1) ? CSUM : DATA;
        end
        CSUM: begin
          if (accept) begin
            state        <= IDLE;
            busy         <= 1'b0;
            bus.rx_ready <= 1'b0;
            if (bus.rx_data == csum) begin
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Abort on silence; expiry never coincides with an accepted byte.
      if (expired) begin
        state        <= IDLE;
        error        <= 1'b1;
        busy         <= 1'b0;
        bus.rx_ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, checksum, header bounds, timeout,
// flow control and mid-session reset.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [10:0] words_loaded;

  imem_loader_if #(.ADDR_W(10)) bus ();

  imem_loader #(
    .ADDR_W     (10),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  frame [0:15];
  int          frame_len;
  logic [9:0]  wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  int          wr_n   = 0;
  int          done_n = 0;

  localparam logic [127:0] GOOD = 128'h0002_12345678_9ABCDEF0_38;
  localparam logic [127:0] BADC = 128'h0002_12345678_9ABCDEF0_39;
  localparam logic [127:0] B2B  = 128'h0003_01020304_05060708_090A0B0C_4E;

  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = bus.imem_addr;
        wr_data[wr_n] = bus.imem_wdata;
      end
      wr_n++;
    end
    if (done === 1'b1) done_n++;
  end

  task automatic load_frame(input logic [127:0] v, input int len);
    frame_len = len;
    for (int i = 0; i < len; i++) frame[i] = v[8*len-1-8*i -: 8];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte and returns on the negedge right after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int k = 0; k < 40 && bus.rx_ready !== 1'b1; k++) @(negedge clk);
    if (bus.rx_ready !== 1'b1) begin
      n_total++;
      $display("FAIL send_byte_wait rx_ready=%b required 1", bus.rx_ready);
    end else begin
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(frame[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_total++;
    if ({bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, cpu_reset,
         busy, done, error, words_loaded} !== 59'd0)
      $display("FAIL reset_outputs got rdy=%b we=%b addr=%h wd=%h cr=%b busy=%b done=%b err=%b wl=%0d required all 0",
               bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, cpu_reset,
               busy, done, error, words_loaded);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({bus.rx_ready, busy} !== 2'b00)
      $display("FAIL reset_idle got rdy=%b busy=%b required 0 0", bus.rx_ready, busy);
    else n_pass++;
  endtask

  task automatic test_good_frame();
    load_frame(GOOD, 11);
    wr_n = 0; done_n = 0;
    pulse_start();
    n_total++;
    if ({busy, cpu_reset, bus.rx_ready} !== 3'b111)
      $display("FAIL start_response got busy=%b cr=%b rdy=%b required 1 1 1", busy, cpu_reset, bus.rx_ready);
    else n_pass++;
    send_range(0, 5);
    n_total++;
    if ({bus.imem_we, bus.rx_ready, bus.imem_addr, bus.imem_wdata} !== {1'b1, 1'b0, 10'd0, 32'h12345678})
      $display("FAIL write0_cycle got we=%b rdy=%b addr=%h wd=%h required 1 0 000 12345678",
               bus.imem_we, bus.rx_ready, bus.imem_addr, bus.imem_wdata);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({bus.imem_we, bus.rx_ready} !== 2'b01)
      $display("FAIL after_write got we=%b rdy=%b required 0 1", bus.imem_we, bus.rx_ready);
    else n_pass++;
    send_range(6, 10);
    n_total++;
    if ({done, busy, cpu_reset, error, bus.rx_ready, words_loaded} !== {5'b10000, 11'd2})
      $display("FAIL good_complete got done=%b busy=%b cr=%b err=%b rdy=%b wl=%0d required 1 0 0 0 0 2",
               done, busy, cpu_reset, error, bus.rx_ready, words_loaded);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || done_n != 1)
      $display("FAIL done_pulse got done=%b pulses=%0d required 0 1", done, done_n);
    else n_pass++;
    n_total++;
    if (wr_n != 2 || wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h12345678 ||
        wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h9ABCDEF0)
      $display("FAIL good_writes got n=%0d a0=%h d0=%h a1=%h d1=%h required 2 000 12345678 001 9abcdef0",
               wr_n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    else n_pass++;
  endtask

  task automatic test_bad_checksum();
    load_frame(BADC, 11);
    wr_n = 0; done_n = 0;
    pulse_start();
    send_range(0, 10);
    n_total++;
    if ({error, done, cpu_reset, busy} !== 4'b1010 || wr_n != 2)
      $display("FAIL bad_csum got err=%b done=%b cr=%b busy=%b writes=%0d required 1 0 1 0 2",
               error, done, cpu_reset, busy, wr_n);
    else n_pass++;
    load_frame(GOOD, 11);
    pulse_start();
    n_total++;
    if (error !== 1'b0)
      $display("FAIL error_clear got err=%b required 0", error);
    else n_pass++;
    send_range(0, 10);
    n_total++;
    if ({done, error, cpu_reset} !== 3'b100)
      $display("FAIL recover_frame got done=%b err=%b cr=%b required 1 0 0", done, error, cpu_reset);
    else n_pass++;
  endtask

  task automatic test_bad_header();
    logic [15:0] hdrs [0:1];
    hdrs[0] = 16'h0000;
    hdrs[1] = 16'h0401;
    for (int h = 0; h < 2; h++) begin
      wr_n = 0;
      pulse_start();
      send_byte(hdrs[h][15:8]);
      send_byte(hdrs[h][7:0]);
      n_total++;
      if ({error, bus.rx_ready, busy} !== 3'b100)
        $display("FAIL bad_header_%h got err=%b rdy=%b busy=%b required 1 0 0",
                 hdrs[h], error, bus.rx_ready, busy);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (wr_n != 0)
        $display("FAIL bad_header_write_%h got writes=%0d required 0", hdrs[h], wr_n);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    load_frame(128'h0001_AABBCC, 5);
    wr_n = 0;
    pulse_start();
    send_range(0, 4);
    repeat (15) @(negedge clk);
    n_total++;
    if ({error, busy} !== 2'b01)
      $display("FAIL timeout_early got err=%b busy=%b required 0 1", error, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({error, busy, cpu_reset, bus.rx_ready} !== 4'b1010 || wr_n != 0)
      $display("FAIL timeout_abort got err=%b busy=%b cr=%b rdy=%b writes=%0d required 1 0 1 0 0",
               error, busy, cpu_reset, bus.rx_ready, wr_n);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int  i, guard, bad, ready_lows;
    logic acc, start_sent;
    load_frame(B2B, 15);
    wr_n = 0; done_n = 0;
    pulse_start();
    i = 0; guard = 0; bad = 0; ready_lows = 0; start_sent = 1'b0;
    bus.rx_data  = frame[0];
    bus.rx_valid = 1'b1;
    while (i < frame_len && guard < 100) begin
      acc = bus.rx_ready;
      if (bus.rx_ready === bus.imem_we) bad++;
      if (bus.rx_ready !== 1'b1) ready_lows++;
      start = (i == 6) && !start_sent;
      if (start) start_sent = 1'b1;
      @(negedge clk);
      guard++;
      if (acc === 1'b1) begin
        i++;
        if (i < frame_len) bus.rx_data = frame[i];
      end
    end
    start = 1'b0;
    bus.rx_valid = 1'b0;
    n_total++;
    if (i != frame_len || bad != 0 || ready_lows != 3)
      $display("FAIL b2b_flow got sent=%0d bad=%0d ready_lows=%0d required 15 0 3", i, bad, ready_lows);
    else n_pass++;
    n_total++;
    if ({done, error, busy, words_loaded} !== {3'b100, 11'd3})
      $display("FAIL b2b_done got done=%b err=%b busy=%b wl=%0d required 1 0 0 3",
               done, error, busy, words_loaded);
    else n_pass++;
    n_total++;
    if (wr_n != 3 || wr_data[0] !== 32'h01020304 || wr_data[1] !== 32'h05060708 ||
        wr_data[2] !== 32'h090A0B0C || wr_addr[2] !== 10'd2)
      $display("FAIL b2b_writes got n=%0d d0=%h d1=%h d2=%h a2=%h required 3 01020304 05060708 090a0b0c 002",
               wr_n, wr_data[0], wr_data[1], wr_data[2], wr_addr[2]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    load_frame(GOOD, 11);
    pulse_start();
    send_range(0, 6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if ({bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, cpu_reset,
         busy, done, error, words_loaded} !== 59'd0)
      $display("FAIL mid_reset got rdy=%b we=%b addr=%h wd=%h cr=%b busy=%b done=%b err=%b wl=%0d required all 0",
               bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, cpu_reset,
               busy, done, error, words_loaded);
    else n_pass++;
    wr_n = 0; done_n = 0;
    pulse_start();
    send_range(0, 10);
    n_total++;
    if ({done, cpu_reset, words_loaded} !== {2'b10, 11'd2} || wr_n != 2 ||
        wr_data[0] !== 32'h12345678 || wr_data[1] !== 32'h9ABCDEF0)
      $display("FAIL after_reset_frame got done=%b cr=%b wl=%0d n=%0d d0=%h d1=%h required 1 0 2 2 12345678 9abcdef0",
               done, cpu_reset, words_loaded, wr_n, wr_data[0], wr_data[1]);
    else n_pass++;
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_header();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
